// File: rtl/issue_ctrl.sv
// Instruction issue queue: circular FIFO between fetch and decode with an optional
// load-use hazard stall on the queue head (enabled by defining ISSUE_CTRL_HAZARD_EN).
module issue_ctrl #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     f_valid,
  input  logic [31:0]              f_ins,
  output logic                     f_ready,
  input  logic                     flush,
  input  logic                     ex_is_load,
  input  logic [4:0]               ex_rd,
  output logic                     d_valid,
  output logic [31:0]              d_ins,
  input  logic                     d_ready,
  output logic                     stall,
  output logic [$clog2(DEPTH):0]   count,
  output logic [15:0]              stall_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [31:0]   NOP_INS  = 32'h0000_0013;

  logic [31:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic          w_stall;
  logic [31:0]   w_head;

  assign w_empty = (r_count == {CW{1'b0}});
  assign w_head  = r_mem[r_rd_ptr];

  // No bypass: readiness depends only on occupancy, never on the consumer.
  assign f_ready = (r_count < FULL_CNT);
  assign w_push  = f_valid & f_ready & ~flush;
  assign d_valid = ~w_empty & ~w_stall & ~flush;
  assign w_pop   = d_valid & d_ready;

  assign d_ins   = w_empty ? NOP_INS : w_head;
  assign count   = r_count;
  assign stall   = w_stall;

  // Entry storage; contents are meaningless until the pointers say otherwise.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= f_ins;
    end
  end

  // Pointers and occupancy; flush wins over any same-cycle push or pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_count  <= {CW{1'b0}};
    end else if (flush) begin
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_count  <= {CW{1'b0}};
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef ISSUE_CTRL_HAZARD_EN
  logic [15:0] r_stall_cnt;
  logic        w_rs1_hit;
  logic        w_rs2_hit;

  function automatic logic f_uses_rs1(input logic [6:0] op);
    case (op)
      7'b0110111, 7'b0010111, 7'b1101111: f_uses_rs1 = 1'b0;
      default:                            f_uses_rs1 = 1'b1;
    endcase
  endfunction

  function automatic logic f_uses_rs2(input logic [6:0] op);
    case (op)
      7'b0110011, 7'b0100011, 7'b1100011: f_uses_rs2 = 1'b1;
      default:                            f_uses_rs2 = 1'b0;
    endcase
  endfunction

  assign w_rs1_hit = f_uses_rs1(w_head[6:0]) && (w_head[19:15] == ex_rd);
  assign w_rs2_hit = f_uses_rs2(w_head[6:0]) && (w_head[24:20] == ex_rd);
  assign w_stall   = ~w_empty & ex_is_load & (ex_rd != 5'd0) & (w_rs1_hit | w_rs2_hit);
  assign stall_cnt = r_stall_cnt;

  // Saturating stall counter; survives flush, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= 16'h0000;
    end else if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'h0001;
    end
  end
`else
  logic w_unused_hazard;

  assign w_unused_hazard = &{1'b0, ex_is_load, ex_rd};
  assign w_stall         = 1'b0;
  assign stall_cnt       = 16'h0000;
`endif

endmodule
